field_set_ctrl: RTL and testbench

FIELD_SET_CTRL -- requirements
Module: field_set_ctrl

---
 rtl/field_set_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_field_set_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/field_set_ctrl.sv
// Time-field set controller: sel/up/down button edge detection, field
// selection FSM, auto-repeat increment/decrement and inactivity timeout.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | clock running or set mode not entered; no pulses, blink = 0
// SET   | field fld selected; up/down issue inc/dec pulses for fld
module field_set_ctrl #(
    parameter int NUM_FIELDS = 6,
    parameter int SEL_W      = 3,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100,
    parameter int TIMEOUT    = 10000,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sel_btn,
    input  logic                  up_btn,
    input  logic                  down_btn,
    output logic [NUM_FIELDS-1:0] inc,
    output logic [NUM_FIELDS-1:0] dec,
    output logic [SEL_W-1:0]      blink,
    output logic                  setting,
    output logic                  timeout_evt
);

    typedef enum logic {IDLE = 1'b0, SET = 1'b1} state_t;

    localparam logic [SEL_W-1:0]      LAST_FLD = SEL_W'(NUM_FIELDS - 1);
    localparam logic [CNT_W-1:0]      DLY_C    = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0]      PER_C    = CNT_W'(REPEAT_PER);
    localparam logic [CNT_W-1:0]      TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [NUM_FIELDS-1:0] ONE_HOT0 = NUM_FIELDS'(1);

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        fld_q, fld_d;
    logic [CNT_W-1:0]        rpt_cnt_q, rpt_cnt_d;
    logic [CNT_W-1:0]        to_cnt_q, to_cnt_d;
    logic                    rep_on_q, rep_on_d;
    logic                    rep_up_q, rep_up_d;
    logic                    rep_fast_q, rep_fast_d;
    logic                    sel_q, up_q, down_q;
    logic                    sel_rise, up_rise, down_rise;
    logic                    pulse_up, pulse_dn, clr_to, tevt_d;
    logic [NUM_FIELDS-1:0]   inc_d, dec_d;
    logic [SEL_W-1:0]        blink_d;

    assign sel_rise  = sel_btn  & ~sel_q;
    assign up_rise   = up_btn   & ~up_q;
    assign down_rise = down_btn & ~down_q;

    // Next-state, counter and output decode
    always_comb begin
        state_d    = state_q;
        fld_d      = fld_q;
        rpt_cnt_d  = rpt_cnt_q;
        to_cnt_d   = to_cnt_q;
        rep_on_d   = rep_on_q;
        rep_up_d   = rep_up_q;
        rep_fast_d = rep_fast_q;
        pulse_up   = 1'b0;
        pulse_dn   = 1'b0;
        clr_to     = 1'b0;
        tevt_d     = 1'b0;

        if (en) begin
            state_d    = IDLE;
            fld_d      = '0;
            rpt_cnt_d  = '0;
            to_cnt_d   = '0;
            rep_on_d   = 1'b0;
            rep_fast_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rpt_cnt_d  = '0;
                    to_cnt_d   = '0;
                    rep_on_d   = 1'b0;
                    rep_fast_d = 1'b0;
                    if (sel_rise) begin
                        state_d = SET;
                        fld_d   = '0;
                    end
                end
                SET: begin
                    if (sel_rise) begin
                        // select wins over a coincident up/down edge and
                        // disarms any repeat held across the field change
                        rep_on_d   = 1'b0;
                        rep_fast_d = 1'b0;
                        rpt_cnt_d  = '0;
                        clr_to     = 1'b1;
                        if (fld_q == LAST_FLD) begin
                            state_d = IDLE;
                            fld_d   = '0;
                        end else begin
                            fld_d = fld_q + SEL_W'(1);
                        end
                    end else if (up_btn && down_btn) begin
                        rep_on_d   = 1'b0;
                        rep_fast_d = 1'b0;
                        rpt_cnt_d  = '0;
                        clr_to     = up_rise | down_rise;
                    end else if (up_rise || down_rise) begin
                        pulse_up   = up_rise;
                        pulse_dn   = down_rise;
                        rep_on_d   = 1'b1;
                        rep_up_d   = up_rise;
                        rep_fast_d = 1'b0;
                        rpt_cnt_d  = CNT_W'(1);
                        clr_to     = 1'b1;
                    end else if (rep_on_q && (rep_up_q ? up_btn : down_btn)) begin
                        if (rpt_cnt_q >= (rep_fast_q ? PER_C : DLY_C)) begin
                            pulse_up   = rep_up_q;
                            pulse_dn   = ~rep_up_q;
                            rpt_cnt_d  = CNT_W'(1);
                            rep_fast_d = 1'b1;
                            clr_to     = 1'b1;
                        end else if (rpt_cnt_q != CNT_MAX) begin
                            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        rep_on_d   = 1'b0;
                        rep_fast_d = 1'b0;
                        rpt_cnt_d  = '0;
                    end

                    if (clr_to) begin
                        to_cnt_d = '0;
                    end else if (to_cnt_q >= TO_LAST) begin
                        state_d    = IDLE;
                        fld_d      = '0;
                        to_cnt_d   = '0;
                        rpt_cnt_d  = '0;
                        rep_on_d   = 1'b0;
                        rep_fast_d = 1'b0;
                        tevt_d     = 1'b1;
                    end else if (to_cnt_q != CNT_MAX) begin
                        to_cnt_d = to_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    fld_d   = '0;
                end
            endcase
        end

        inc_d   = pulse_up ? (ONE_HOT0 << fld_q) : '0;
        dec_d   = pulse_dn ? (ONE_HOT0 << fld_q) : '0;
        blink_d = (state_d == SET) ? (fld_d + SEL_W'(1)) : '0;
    end

    // State, counters, button history and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fld_q       <= '0;
            rpt_cnt_q   <= '0;
            to_cnt_q    <= '0;
            rep_on_q    <= 1'b0;
            rep_up_q    <= 1'b0;
            rep_fast_q  <= 1'b0;
            sel_q       <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            inc         <= '0;
            dec         <= '0;
            blink       <= '0;
            setting     <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            state_q     <= state_d;
            fld_q       <= fld_d;
            rpt_cnt_q   <= rpt_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rep_on_q    <= rep_on_d;
            rep_up_q    <= rep_up_d;
            rep_fast_q  <= rep_fast_d;
            sel_q       <= sel_btn;
            up_q        <= up_btn;
            down_q      <= down_btn;
            inc         <= inc_d;
            dec         <= dec_d;
            blink       <= blink_d;
            setting     <= (state_d == SET);
            timeout_evt <= tevt_d;
        end
    end

endmodule

// File: tb/tb_field_set_ctrl.sv
// Bench for field_set_ctrl: directed scenarios then random button traffic,
// predicted by a cycle-count reference model and checked via a scoreboard.
module tb_field_set_ctrl;

    localparam int NF  = 6;
    localparam int SW  = 3;
    localparam int DLY = 4;
    localparam int PER = 2;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sel_btn = 1'b0;
    logic          up_btn = 1'b0;
    logic          down_btn = 1'b0;
    logic [NF-1:0] inc, dec;
    logic [SW-1:0] blink;
    logic          setting, timeout_evt;

    int checks = 0;
    int errors = 0;

    logic [2*NF+SW+1:0] expq[$];

    field_set_ctrl #(
        .NUM_FIELDS(NF), .SEL_W(SW), .REPEAT_DLY(DLY),
        .REPEAT_PER(PER), .TIMEOUT(TO), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_btn(sel_btn),
        .up_btn(up_btn), .down_btn(down_btn), .inc(inc), .dec(dec),
        .blink(blink), .setting(setting), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    // reference model: press time, last activity time, selected field
    bit m_set = 0;
    int m_fld = 0;
    int m_press = -1;
    int m_last = 0;
    int m_cyc = 0;
    bit m_dirup = 0;
    bit m_ps = 0, m_pu = 0, m_pd = 0;

    task automatic model_step(input bit r, input bit e, input bit s,
                              input bit u, input bit d,
                              output logic [2*NF+SW+1:0] exp_v);
        logic [NF-1:0] mi = '0;
        logic [NF-1:0] md = '0;
        logic [SW-1:0] b;
        bit evt = 0;
        bit pulse = 0;
        bit rs, ru, rd;
        int k;
        if (!r) begin
            m_set = 0; m_fld = 0; m_press = -1;
            m_ps = 0; m_pu = 0; m_pd = 0;
            m_cyc++;
            exp_v = '0;
            return;
        end
        rs = s && !m_ps;
        ru = u && !m_pu;
        rd = d && !m_pd;
        if (e) begin
            m_set = 0; m_fld = 0; m_press = -1;
        end else if (!m_set) begin
            if (rs) begin
                m_set = 1; m_fld = 0; m_last = m_cyc; m_press = -1;
            end
        end else begin
            if (rs || ru || rd) m_last = m_cyc;
            if (rs) begin
                m_press = -1;
                if (m_fld == NF - 1) begin
                    m_set = 0; m_fld = 0;
                end else begin
                    m_fld++;
                end
            end else if (u && d) begin
                m_press = -1;
            end else if (ru || rd) begin
                m_press = m_cyc; m_dirup = ru; pulse = 1;
            end else if (m_press >= 0 && (m_dirup ? u : d)) begin
                k = m_cyc - m_press;
                if (k >= DLY && (k - DLY) % PER == 0) begin
                    pulse = 1; m_last = m_cyc;
                end
            end else begin
                m_press = -1;
            end
            if (pulse) begin
                if (m_dirup) mi[m_fld] = 1'b1;
                else md[m_fld] = 1'b1;
            end
            if (m_set && (m_cyc - m_last) >= TO) begin
                m_set = 0; m_fld = 0; m_press = -1; evt = 1;
            end
        end
        m_ps = s; m_pu = u; m_pd = d;
        m_cyc++;
        b = m_set ? SW'(m_fld + 1) : '0;
        exp_v = {mi, md, b, m_set, evt};
    endtask

    task automatic drive(input bit r, input bit e, input bit s,
                         input bit u, input bit d);
        logic [2*NF+SW+1:0] ev;
        @(negedge clk);
        rst_n = r; en = e; sel_btn = s; up_btn = u; down_btn = d;
        if (!r) begin
            #1;
            checks++;
            if ({inc, dec, blink, setting, timeout_evt} !== '0) begin
                errors++;
                $display("FAIL async_reset t=%0t got %h expected 0", $time,
                         {inc, dec, blink, setting, timeout_evt});
            end
        end
        model_step(r, e, s, u, d, ev);
        expq.push_back(ev);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
    endtask

    task automatic sel_press();
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
    endtask

    // monitor: compare DUT outputs to the oldest prediction each cycle
    initial begin
        logic [2*NF+SW+1:0] ev, got;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                ev = expq.pop_front();
                got = {inc, dec, blink, setting, timeout_evt};
                checks++;
                if (got !== ev) begin
                    errors++;
                    $display("FAIL outputs t=%0t got inc=%b dec=%b blink=%0d setting=%b tevt=%b expected inc=%b dec=%b blink=%0d setting=%b tevt=%b",
                             $time, got[16:11], got[10:5], got[4:2], got[1], got[0],
                             ev[16:11], ev[10:5], ev[4:2], ev[1], ev[0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        bit s, u, d, e;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        idle(2);

        // seven select presses walk through all fields then exit
        for (int i = 0; i < 7; i++) sel_press();
        idle(2);

        // auto-repeat on field 2
        for (int i = 0; i < 3; i++) sel_press();
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 1, 0);
        idle(2);

        // up+down together, then release down while up held
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 1, 0);
        // quiet until timeout
        idle(25);

        // en forces exit at field 3
        for (int i = 0; i < 4; i++) sel_press();
        drive(1, 1, 0, 0, 0);
        idle(3);

        // reset during auto-repeat
        sel_press();
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        // button still held at release counts as a fresh edge
        drive(1, 0, 0, 1, 0);
        idle(2);

        // sel and up together at field 0
        sel_press();
        drive(1, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0);
        // down repeat on field 1
        for (int i = 0; i < 9; i++) drive(1, 0, 0, 0, 1);
        idle(2);

        // random traffic
        s = 0; u = 0; d = 0; e = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                drive(0, 0, s, u, d);
                drive(0, 0, s, u, d);
            end else if ($urandom_range(99) == 0) begin
                s = 0; u = 0; d = 0; e = 0;
                idle(TO + 3);
            end else begin
                if ($urandom_range(11) == 0) s = ~s;
                if ($urandom_range(5) == 0) u = ~u;
                if ($urandom_range(7) == 0) d = ~d;
                if (e) e = ($urandom_range(3) != 0);
                else   e = ($urandom_range(59) == 0);
                drive(1, e, s, u, d);
            end
        end
        idle(3);

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
